// File: rtl/im_comp_pkg.sv
// Shared types and helpers for the image compression job controller.
// Holds the FSM state encoding, buffer index type and frame size helper.
package im_comp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_START,
        ST_ACK,
        ST_RUN,
        ST_ERR
    } state_t;

    typedef logic [1:0] buf_idx_t;

    function automatic int unsigned frame_words(input int unsigned width, input int unsigned height);
        return width * height;
    endfunction

endpackage

// File: rtl/tribuf_idx.sv
// Triple-buffer index rotation: writer, ready and reader slots always hold
// a permutation of {0,1,2}, so the reader can never alias the writer.
module tribuf_idx
    import im_comp_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     frame_done,
    input  logic     consume,
    output buf_idx_t wr_next,
    output buf_idx_t rd_next,
    output logic     rdy_valid,
    output logic     drop
);

    buf_idx_t wr_reg, rdy_reg, rd_reg;
    buf_idx_t rdy_next;
    logic     valid_reg, valid_next;

    always_comb begin
        wr_next    = wr_reg;
        rdy_next   = rdy_reg;
        rd_next    = rd_reg;
        valid_next = valid_reg;
        drop       = 1'b0;
        if (consume && frame_done) begin
            // Reader takes the older ready frame; the fresh one becomes ready.
            rd_next    = rdy_reg;
            rdy_next   = wr_reg;
            wr_next    = rd_reg;
            valid_next = 1'b1;
        end else if (frame_done) begin
            wr_next    = rdy_reg;
            rdy_next   = wr_reg;
            valid_next = 1'b1;
            drop       = valid_reg;
        end else if (consume) begin
            rd_next    = rdy_reg;
            rdy_next   = rd_reg;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_reg    <= 2'd0;
            rdy_reg   <= 2'd1;
            rd_reg    <= 2'd2;
            valid_reg <= 1'b0;
        end else begin
            wr_reg    <= wr_next;
            rdy_reg   <= rdy_next;
            rd_reg    <= rd_next;
            valid_reg <= valid_next;
        end
    end

    assign rdy_valid = valid_reg;

endmodule

// File: rtl/im_comp_ctrl.sv
// Compression job scheduler over a triple-buffered capture stream:
// hands the newest complete frame to the compressor and tracks job health.
module im_comp_ctrl
    import im_comp_pkg::*;
#(
    parameter int pIN_IM_WIDTH  = 640,
    parameter int pIN_IM_HEIGHT = 480,
    parameter int pPTR_W        = 24,
    parameter int pACK_TO       = 64
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              ienable,
    input  logic              iframe_done,
    output logic [pPTR_W-1:0] owr_base_ptr,
    output logic              ostart_work,
    output logic [pPTR_W-1:0] odata_start_ptr,
    input  logic              imodule_work_f,
    input  logic              imodule_done_f,
    output logic              obusy,
    output logic [15:0]       oframe_cnt,
    output logic [15:0]       odrop_cnt,
    output logic              otimeout_err
);

    localparam int unsigned FRAME_WORDS = frame_words(pIN_IM_WIDTH, pIN_IM_HEIGHT);
    localparam int          TMR_W       = $clog2(pACK_TO + 1);

    function automatic logic [pPTR_W-1:0] buf_base(input buf_idx_t idx);
        case (idx)
            2'd1:    buf_base = pPTR_W'(FRAME_WORDS);
            2'd2:    buf_base = pPTR_W'(2 * FRAME_WORDS);
            default: buf_base = '0;
        endcase
    endfunction

    state_t             state_reg, state_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [15:0]        frame_cnt_reg, drop_cnt_reg;
    logic [pPTR_W-1:0]  wr_ptr_reg, data_ptr_reg;
    logic               job_done, consume, frame_evt, rdy_valid, drop;
    buf_idx_t           wr_next, rd_next;

    assign frame_evt = iframe_done && (state_reg != ST_IDLE);
    assign consume   = (state_reg == ST_WAIT_FRAME) && ienable && rdy_valid;

    tribuf_idx u_tribuf_idx (
        .clk        (iclk),
        .rst_n      (irst_n),
        .frame_done (frame_evt),
        .consume    (consume),
        .wr_next    (wr_next),
        .rd_next    (rd_next),
        .rdy_valid  (rdy_valid),
        .drop       (drop)
    );

    always_comb begin
        state_next = state_reg;
        job_done   = 1'b0;
        case (state_reg)
            ST_IDLE:       if (ienable) state_next = ST_WAIT_FRAME;
            ST_WAIT_FRAME: begin
                if (!ienable)       state_next = ST_IDLE;
                else if (rdy_valid) state_next = ST_START;
            end
            ST_START:      state_next = ST_ACK;
            ST_ACK: begin
                // A job short enough to finish before acknowledging exits like RUN.
                if (imodule_done_f) begin
                    job_done   = 1'b1;
                    state_next = ienable ? ST_WAIT_FRAME : ST_IDLE;
                end else if (imodule_work_f) begin
                    state_next = ST_RUN;
                end else if (timer_reg >= TMR_W'(pACK_TO - 1)) begin
                    state_next = ST_ERR;
                end
            end
            ST_RUN: begin
                if (imodule_done_f) begin
                    job_done   = 1'b1;
                    state_next = ienable ? ST_WAIT_FRAME : ST_IDLE;
                end
            end
            ST_ERR:        if (!ienable) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // Timer counts the START cycle too, so the limit is measured from ostart_work.
    always_comb begin
        timer_next = '0;
        if (state_reg == ST_START)    timer_next = TMR_W'(1);
        else if (state_reg == ST_ACK) timer_next = timer_reg + TMR_W'(1);
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            frame_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
            wr_ptr_reg    <= '0;
            data_ptr_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            wr_ptr_reg <= buf_base(wr_next);
            if (job_done)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            if (drop && (drop_cnt_reg != 16'hFFFF))
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            if (consume)
                data_ptr_reg <= buf_base(rd_next);
        end
    end

    assign owr_base_ptr    = wr_ptr_reg;
    assign odata_start_ptr = data_ptr_reg;
    assign ostart_work     = (state_reg == ST_START);
    assign obusy           = (state_reg == ST_START) || (state_reg == ST_ACK) || (state_reg == ST_RUN);
    assign oframe_cnt      = frame_cnt_reg;
    assign odrop_cnt       = drop_cnt_reg;
    assign otimeout_err    = (state_reg == ST_ERR);

endmodule

// File: tb/tb_im_comp_ctrl.sv
// Directed bench for im_comp_ctrl: job starts are checked by a scoreboard
// monitor, status outputs by direct checks after each scenario step.
module tb_im_comp_ctrl;
    import im_comp_pkg::*;

    localparam int FRAME = 640 * 480;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, frame_done, work_f, done_f;
    logic [23:0] owr_base_ptr, odata_start_ptr;
    logic        ostart_work, obusy, otimeout_err;
    logic [15:0] oframe_cnt, odrop_cnt;

    typedef struct {
        int          cyc;
        logic [23:0] ptr;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   a, s;

    im_comp_ctrl dut (
        .iclk            (clk),
        .irst_n          (rst_n),
        .ienable         (enable),
        .iframe_done     (frame_done),
        .owr_base_ptr    (owr_base_ptr),
        .ostart_work     (ostart_work),
        .odata_start_ptr (odata_start_ptr),
        .imodule_work_f  (work_f),
        .imodule_done_f  (done_f),
        .obusy           (obusy),
        .oframe_cnt      (oframe_cnt),
        .odrop_cnt       (odrop_cnt),
        .otimeout_err    (otimeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
    endtask

    // Monitor: every job start is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n && ostart_work) begin
            if (exp_q.size() == 0) begin
                check("start_unexpected", 32'(ostart_work), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("job start at cycle %0d ptr %0d (expected cycle %0d ptr %0d)",
                         cyc, odata_start_ptr, e.cyc, e.ptr);
                check("start_cycle", 32'(cyc), 32'(e.cyc));
                check("start_ptr", 32'(odata_start_ptr), 32'(e.ptr));
            end
        end
        if (rst_n && obusy)
            check("no_tearing", 32'(owr_base_ptr != odata_start_ptr), 32'd1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; frame_done = 1'b0; work_f = 1'b0; done_f = 1'b0;
        tick(3);
        check("rst_wr_ptr", 32'(owr_base_ptr), 32'd0);
        check("rst_data_ptr", 32'(odata_start_ptr), 32'd0);
        check("rst_start", 32'(ostart_work), 32'd0);
        check("rst_busy", 32'(obusy), 32'd0);
        check("rst_frame_cnt", 32'(oframe_cnt), 32'd0);
        check("rst_drop_cnt", 32'(odrop_cnt), 32'd0);
        check("rst_timeout", 32'(otimeout_err), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Frame ignored while idle
        pulse_frame();
        check("idle_ignore_wr_ptr", 32'(owr_base_ptr), 32'd0);

        // First job: latency, ack at start+1, done 100 cycles after ack
        enable = 1'b1;
        tick(1);
        check("state_wait", 32'(dut.state_reg), 32'(ST_WAIT_FRAME));
        exp_q.push_back('{cyc + 2, 24'd0});
        pulse_frame();
        check("wr_ptr_after_frame", 32'(owr_base_ptr), 32'(FRAME));
        tick(1);
        check("busy_in_start", 32'(obusy), 32'd1);
        tick(1);
        work_f = 1'b1;
        a = cyc;

        // Three frames during one job: two drops, newest buffer kept
        tick(10);
        pulse_frame();
        check("wr_ptr_run1", 32'(owr_base_ptr), 32'(2 * FRAME));
        check("drop_run1", 32'(odrop_cnt), 32'd0);
        tick(5);
        pulse_frame();
        check("wr_ptr_run2", 32'(owr_base_ptr), 32'(FRAME));
        check("drop_run2", 32'(odrop_cnt), 32'd1);
        tick(5);
        pulse_frame();
        check("wr_ptr_run3", 32'(owr_base_ptr), 32'(2 * FRAME));
        check("drop_run3", 32'(odrop_cnt), 32'd2);
        while (cyc < a + 100) tick(1);
        done_f = 1'b1;
        exp_q.push_back('{cyc + 2, 24'(FRAME)});
        tick(1);
        done_f = 1'b0; work_f = 1'b0;
        check("busy_after_done", 32'(obusy), 32'd0);
        check("frame_cnt_job1", 32'(oframe_cnt), 32'd1);
        check("state_after_done", 32'(dut.state_reg), 32'(ST_WAIT_FRAME));
        check("drop_after_job1", 32'(odrop_cnt), 32'd2);

        // Ack timeout on the job started from the buffered frame
        s = cyc + 1;
        while (cyc < s + 63) tick(1);
        check("timeout_not_yet", 32'(otimeout_err), 32'd0);
        check("state_ack_before_to", 32'(dut.state_reg), 32'(ST_ACK));
        tick(1);
        check("timeout_set", 32'(otimeout_err), 32'd1);
        check("busy_in_err", 32'(obusy), 32'd0);
        enable = 1'b0;
        tick(1);
        check("timeout_cleared", 32'(otimeout_err), 32'd0);
        check("state_idle_after_err", 32'(dut.state_reg), 32'(ST_IDLE));

        // Frame and job done in the same cycle
        enable = 1'b1;
        tick(1);
        exp_q.push_back('{cyc + 2, 24'(2 * FRAME)});
        pulse_frame();
        check("wr_ptr_job3", 32'(owr_base_ptr), 32'd0);
        tick(2);
        work_f = 1'b1;
        tick(5);
        exp_q.push_back('{cyc + 2, 24'd0});
        frame_done = 1'b1; done_f = 1'b1;
        tick(1);
        frame_done = 1'b0; done_f = 1'b0; work_f = 1'b0;
        check("frame_cnt_simul", 32'(oframe_cnt), 32'd2);
        check("drop_simul", 32'(odrop_cnt), 32'd2);
        check("wr_ptr_simul", 32'(owr_base_ptr), 32'(FRAME));

        // Disable during a running job: job completes, then idle
        tick(2);
        work_f = 1'b1; enable = 1'b0;
        tick(5);
        check("busy_disabled_run", 32'(obusy), 32'd1);
        check("state_run_disabled", 32'(dut.state_reg), 32'(ST_RUN));
        done_f = 1'b1;
        tick(1);
        done_f = 1'b0; work_f = 1'b0;
        check("state_idle_after_job", 32'(dut.state_reg), 32'(ST_IDLE));
        check("frame_cnt_job4", 32'(oframe_cnt), 32'd3);

        // Reset mid-run applies without waiting for a clock edge
        enable = 1'b1;
        tick(1);
        exp_q.push_back('{cyc + 2, 24'(FRAME)});
        pulse_frame();
        check("wr_ptr_job5", 32'(owr_base_ptr), 32'(2 * FRAME));
        tick(2);
        work_f = 1'b1;
        tick(4);
        check("busy_before_rst", 32'(obusy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_ptr", 32'(owr_base_ptr), 32'd0);
        check("arst_data_ptr", 32'(odata_start_ptr), 32'd0);
        check("arst_busy", 32'(obusy), 32'd0);
        check("arst_start", 32'(ostart_work), 32'd0);
        check("arst_frame_cnt", 32'(oframe_cnt), 32'd0);
        check("arst_drop_cnt", 32'(odrop_cnt), 32'd0);
        check("arst_timeout", 32'(otimeout_err), 32'd0);
        check("arst_state", 32'(dut.state_reg), 32'(ST_IDLE));
        work_f = 1'b0; enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Short job: done arrives in place of the acknowledge
        enable = 1'b1;
        tick(1);
        exp_q.push_back('{cyc + 2, 24'd0});
        pulse_frame();
        check("wr_ptr_short", 32'(owr_base_ptr), 32'(FRAME));
        tick(2);
        done_f = 1'b1;
        tick(1);
        done_f = 1'b0;
        check("state_after_short", 32'(dut.state_reg), 32'(ST_WAIT_FRAME));
        check("frame_cnt_short", 32'(oframe_cnt), 32'd1);
        check("busy_after_short", 32'(obusy), 32'd0);

        tick(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/im_comp_ctrl.md
IM_COMP_CTRL -- requirements
Module: im_comp_ctrl

Interface
REQ-001 SHALL have parameter pIN_IM_WIDTH, default 640, input frame width in pixels.
REQ-002 SHALL have parameter pIN_IM_HEIGHT, default 480, input frame height in pixels.
REQ-003 SHALL have parameter pPTR_W, default 24, width of every buffer pointer.
REQ-004 SHALL have parameter pACK_TO, default 64, cycles allowed from ostart_work to imodule_work_f.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports: iclk  in  1  clock.
REQ-006 SHALL have irst_n  in  1  async active-low reset.
REQ-007 SHALL have ienable  in  1  level; 1 = schedule compression jobs.
REQ-008 SHALL have iframe_done  in  1  one-cycle pulse; capture writer has completed a frame into owr_base_ptr.
REQ-009 SHALL have owr_base_ptr  out  pPTR_W  base word address of the capture write buffer.
REQ-010 SHALL have ostart_work  out  1  one-cycle job start pulse to the compressor.
REQ-011 SHALL have odata_start_ptr  out  pPTR_W  base address of the frame to compress.
REQ-012 SHALL have imodule_work_f  in  1  compressor busy level (acknowledges start).
REQ-013 SHALL have imodule_done_f  in  1  one-cycle pulse; compressor job finished.
REQ-014 SHALL have obusy  out  1, oframe_cnt  out  16  completed jobs, odrop_cnt  out  16  overwritten frames, otimeout_err  out  1  sticky ack timeout.

Function
REQ-015 SHALL manage three frame buffers (triple buffering); buffer k base = k * pIN_IM_WIDTH * pIN_IM_HEIGHT (0, 307200, 614400 at defaults).
REQ-016 SHALL hold three distinct indices wr_idx, rdy_idx, rd_idx plus flag rdy_valid; all three indices always distinct.
REQ-017 SHALL, on iframe_done in any state except IDLE, swap wr_idx and rdy_idx and set rdy_valid; if rdy_valid was already 1, odrop_cnt increments (saturating at 0xFFFF).
REQ-018 SHALL ignore iframe_done in IDLE.
REQ-019 SHALL drive owr_base_ptr = base(wr_idx), registered, updated the cycle after the swap.
REQ-020 SHALL implement FSM IDLE, WAIT_FRAME, START, ACK, RUN, ERR.
REQ-021 IDLE: ienable=1 -> WAIT_FRAME.
REQ-022 WAIT_FRAME: ienable=0 -> IDLE; else rdy_valid=1 -> swap rd_idx and rdy_idx, clear rdy_valid, -> START.
REQ-023 START: ostart_work=1 for exactly this cycle; odata_start_ptr = base(rd_idx), held stable until the next START; -> ACK.
REQ-024 ACK: imodule_work_f=1 -> RUN; imodule_done_f=1 (short job) -> RUN exit handling of REQ-025 directly; pACK_TO cycles elapsed without either -> ERR.
REQ-025 RUN: on imodule_done_f, oframe_cnt increments (wrapping), -> WAIT_FRAME if ienable=1, else IDLE; deasserting ienable in RUN/ACK SHALL NOT abort the job.
REQ-026 ERR: otimeout_err=1; remains until ienable=0, then -> IDLE with otimeout_err cleared.
REQ-027 Simultaneous iframe_done and imodule_done_f: both take effect; the new frame is visible in WAIT_FRAME the next cycle, giving ostart_work 2 cycles after done.
REQ-028 Minimum latency iframe_done (in WAIT_FRAME) -> ostart_work = 2 cycles.
REQ-029 obusy = 1 in START, ACK, RUN; 0 otherwise.
REQ-030 rd_idx SHALL never equal wr_idx while obusy=1 (no tearing).

Reset
REQ-031 SHALL, while irst_n=0, force: state IDLE, wr_idx=0, rdy_idx=1, rd_idx=2, rdy_valid=0, owr_base_ptr=0, odata_start_ptr=0, ostart_work=0, obusy=0, counters 0, otimeout_err=0, ack timer 0.
REQ-032 Reset asserted mid-job SHALL return to these values immediately; the compressor is restarted only by a new ostart_work.

Structure
REQ-033 Package im_comp_pkg SHALL hold the FSM state enum, buffer index typedef (2 bits) and frame-size constant function.
REQ-034 Index rotation (REQ-016/017/022) SHALL be a sub-module tribuf_idx; FSM, timer and counters stay in im_comp_ctrl.

Verification
REQ-035 Reset, ienable=1, iframe_done at t0 -> ostart_work at t0+2 with odata_start_ptr=0; owr_base_ptr=307200 from t0+1.
REQ-036 Ack at start+1, done 100 cycles later -> oframe_cnt=1, obusy low the cycle after done, state WAIT_FRAME.
REQ-037 Three iframe_done during one RUN -> odrop_cnt=2; next job uses the last completed buffer; rd_idx never equals wr_idx.
REQ-038 No imodule_work_f after ostart_work -> otimeout_err=1 at cycle start+64; ienable=0 -> cleared, IDLE.
REQ-039 iframe_done and imodule_done_f in same cycle -> oframe_cnt increments and ostart_work exactly 2 cycles later.
REQ-040 irst_n low mid-RUN -> all outputs at REQ-031 values asynchronously; ienable low during RUN -> job completes, then IDLE.
